// File: rtl/fifo_nino.sv
// ---------------------------------------------------------------------------
// fifo_nino -- multi-lane in-order FIFO (N writes in, N reads out per cycle)
//
// Sits between superscalar pipeline stages (fetch->decode, decode->rename).
// Up to W_PORTS entries are accepted and up to R_PORTS entries are released
// per clock. Storage is flop based, so read data is combinational from the
// head; a write into an empty FIFO is visible on lane 0 one cycle later
// (no same-cycle bypass).
//
// Optional feature macro: FIFO_NINO_WATERMARK_EN
//   When defined, adds o_count (used entries) and o_almost_full
//   (used >= ALMOST_FULL). When undefined, both ports are absent and
//   ALMOST_FULL is ignored.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset (wins over everything)
//   i_w_e          per-lane write request, contiguous prefix
//   i_w_data       lane j at [j*WIDTH +: WIDTH]
//   o_w_ready      lane j may write this cycle
//   o_w_ack        registered: lane j write accepted last cycle
//   i_r_e          per-lane pop request, contiguous prefix
//   o_r_data       lane k shows entry k positions behind the head
//   o_r_valid      lane k data valid
//   o_r_ack        registered: lane k pop accepted last cycle
//   i_flush        discard all contents (wins over requests)
//   o_full         no free entries
//   o_empty        no used entries
//   o_count        used entries            (macro only)
//   o_almost_full  used >= ALMOST_FULL     (macro only)
// ---------------------------------------------------------------------------
module fifo_nino #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int W_PORTS     = 2,
    parameter int R_PORTS     = 2,
    parameter int ALMOST_FULL = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [W_PORTS-1:0]         i_w_e,
    input  logic [W_PORTS*WIDTH-1:0]   i_w_data,
    output logic [W_PORTS-1:0]         o_w_ready,
    output logic [W_PORTS-1:0]         o_w_ack,
    input  logic [R_PORTS-1:0]         i_r_e,
    output logic [R_PORTS*WIDTH-1:0]   o_r_data,
    output logic [R_PORTS-1:0]         o_r_valid,
    output logic [R_PORTS-1:0]         o_r_ack,
    input  logic                       i_flush,
    output logic                       o_full,
    output logic                       o_empty
`ifdef FIFO_NINO_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_almost_full
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]    r_w_ptr;
    logic [PW-1:0]    r_r_ptr;
    logic [CW-1:0]    r_used;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0]      w_free;
    logic [W_PORTS-1:0] w_w_acc;
    logic [R_PORTS-1:0] w_r_acc;
    logic [CW-1:0]      w_nw;
    logic [CW-1:0]      w_nr;
    logic [CW:0]        w_used_sum;

    // Status and per-lane ready/valid, all from start-of-cycle occupancy.
    // Entries popped this cycle never free space for this cycle's writes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_free    = CW'(DEPTH) - r_used;
        o_w_ready = '0;
        o_r_valid = '0;
        o_r_data  = '0;
        for (int j = 0; j < W_PORTS; j++) begin
            o_w_ready[j] = (w_free > CW'(j));
        end
        for (int k = 0; k < R_PORTS; k++) begin
            o_r_valid[k]              = (r_used > CW'(k));
            o_r_data[k*WIDTH +: WIDTH] = r_mem[r_r_ptr + PW'(k)];
        end
        o_full  = (w_free == '0);
        o_empty = (r_used == '0);
    end

    // Accept masks and their popcounts. Requests on lanes that are not
    // ready/valid are dropped without an ack; the producer retries.
    always_comb begin
        w_w_acc = i_w_e & o_w_ready;
        w_r_acc = i_r_e & o_r_valid;
        w_nw    = '0;
        w_nr    = '0;
        for (int j = 0; j < W_PORTS; j++) begin
            w_nw = w_nw + CW'(w_w_acc[j]);
        end
        for (int k = 0; k < R_PORTS; k++) begin
            w_nr = w_nr + CW'(w_r_acc[k]);
        end
        // One extra bit so used + nw cannot wrap before nr is subtracted.
        w_used_sum = {1'b0, r_used} + {1'b0, w_nw} - {1'b0, w_nr};
    end

    // Control state: pointers, occupancy and acks.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples start-of-cycle values regardless of block order.
        if (i_rst || i_flush) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_used  <= '0;
            o_w_ack <= '0;
            o_r_ack <= '0;
        end else begin
            r_w_ptr <= r_w_ptr + PW'(w_nw);
            r_r_ptr <= r_r_ptr + PW'(w_nr);
            r_used  <= w_used_sum[CW-1:0];
            o_w_ack <= w_w_acc;
            o_r_ack <= w_r_acc;
        end
    end

    // Data storage.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array is deliberately not reset; its contents
        // are only observable through o_r_valid, which reset clears.
        if (!i_rst && !i_flush) begin
            for (int j = 0; j < W_PORTS; j++) begin
                if (w_w_acc[j]) begin
                    r_mem[r_w_ptr + PW'(j)] <= i_w_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef FIFO_NINO_WATERMARK_EN
    assign o_count       = r_used;
    assign o_almost_full = (r_used >= CW'(ALMOST_FULL));
`endif

`ifndef SYNTHESIS
    // Request masks must be contiguous prefixes (2^n - 1 patterns).
    logic w_w_prefix;
    logic w_r_prefix;
    assign w_w_prefix = ((i_w_e & (i_w_e + W_PORTS'(1))) == '0);
    assign w_r_prefix = ((i_r_e & (i_r_e + R_PORTS'(1))) == '0);

    a_w_prefix: assert property (@(posedge i_clk) disable iff (i_rst) w_w_prefix);
    a_r_prefix: assert property (@(posedge i_clk) disable iff (i_rst) w_r_prefix);
`endif

endmodule

// File: tb/tb_fifo_nino.sv
// ---------------------------------------------------------------------------
// tb_fifo_nino -- self-checking bench for fifo_nino (WIDTH=32, DEPTH=8,
// W_PORTS=2, R_PORTS=2). A table of per-cycle vectors carries inputs and the
// hand-computed post-edge outputs; a short hand-written sequence then checks
// start-of-cycle ready/valid on a full FIFO that is popped and written.
// ---------------------------------------------------------------------------
module tb_fifo_nino;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  w_e;
    logic [63:0] w_data;
    logic [1:0]  w_ready;
    logic [1:0]  w_ack;
    logic [1:0]  r_e;
    logic [63:0] r_data;
    logic [1:0]  r_valid;
    logic [1:0]  r_ack;
    logic        flush;
    logic        full;
    logic        empty;
`ifdef FIFO_NINO_WATERMARK_EN
    logic [3:0]  count;
    logic        almost_full;
`endif

    fifo_nino #(
        .WIDTH(32), .DEPTH(8), .W_PORTS(2), .R_PORTS(2), .ALMOST_FULL(6)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_w_e     (w_e),
        .i_w_data  (w_data),
        .o_w_ready (w_ready),
        .o_w_ack   (w_ack),
        .i_r_e     (r_e),
        .o_r_data  (r_data),
        .o_r_valid (r_valid),
        .o_r_ack   (r_ack),
        .i_flush   (flush),
        .o_full    (full),
        .o_empty   (empty)
`ifdef FIFO_NINO_WATERMARK_EN
        ,
        .o_count       (count),
        .o_almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  w_e;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [1:0]  r_e;
        logic [1:0]  w_ack;
        logic [1:0]  r_ack;
        logic [1:0]  r_valid;
        logic [1:0]  w_ready;
        logic        full;
        logic        empty;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    function automatic vec_t mk(
        input logic rst_i, input logic flush_i, input logic [1:0] we,
        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] re,
        input logic [1:0] wack, input logic [1:0] rack, input logic [1:0] rv,
        input logic [1:0] wrdy, input logic fl, input logic em,
        input logic [31:0] q0, input logic [31:0] q1);
        vec_t v;
        v.rst = rst_i; v.flush = flush_i; v.w_e = we; v.wd0 = d0; v.wd1 = d1;
        v.r_e = re; v.w_ack = wack; v.r_ack = rack; v.r_valid = rv;
        v.w_ready = wrdy; v.full = fl; v.empty = em; v.rd0 = q0; v.rd1 = q1;
        return v;
    endfunction

    vec_t vecs[$];

    // Drive one cycle's inputs at the falling edge.
    task automatic drive(input logic rs, input logic fl, input logic [1:0] we,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] re);
        @(negedge clk);
        rst = rs; flush = fl; w_e = we; w_data = {d1, d0}; r_e = re;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; w_e = '0; w_data = '0; r_e = '0;

        //                rst flsh w_e   wd0     wd1     r_e | w_ack r_ack valid  wrdy  full empty rd0     rd1
        vecs.push_back(mk(1, 0, 2'b00, 32'h0,  32'h0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 2'b11, 32'hA0, 32'hA1, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'hA0, 32'hA1));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 0, 1, 32'h0,  32'h0));
        // fill with 0..7
        vecs.push_back(mk(0, 0, 2'b11, 32'h0,  32'h1,  2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h0,  32'h1));
        vecs.push_back(mk(0, 0, 2'b11, 32'h2,  32'h3,  2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h0,  32'h1));
        vecs.push_back(mk(0, 0, 2'b11, 32'h4,  32'h5,  2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h0,  32'h1));
        vecs.push_back(mk(0, 0, 2'b11, 32'h6,  32'h7,  2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1, 0, 32'h0,  32'h1));
        // write attempt while full is dropped
        vecs.push_back(mk(0, 0, 2'b11, 32'hEE, 32'hEF, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 32'h0,  32'h1));
        // full + pop 2 + write 2: space judged before the pop, writes dropped
        vecs.push_back(mk(0, 0, 2'b11, 32'h8,  32'h9,  2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0, 32'h2,  32'h3));
        // 6 entries + pop 2 + write 2: count steady, head advances
        vecs.push_back(mk(0, 0, 2'b11, 32'h8,  32'h9,  2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 0, 0, 32'h4,  32'h5));
        vecs.push_back(mk(0, 0, 2'b11, 32'hA,  32'hB,  2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 1, 0, 32'h4,  32'h5));
        // drain across the pointer wrap
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0, 32'h6,  32'h7));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0, 32'h8,  32'h9));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0, 32'hA,  32'hB));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b01, 2'b00, 2'b01, 2'b01, 2'b11, 0, 0, 32'hB,  32'h0));
        // build up to 7 entries
        vecs.push_back(mk(0, 0, 2'b11, 32'hC,  32'hD,  2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'hB,  32'hC));
        vecs.push_back(mk(0, 0, 2'b11, 32'hE,  32'hF,  2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'hB,  32'hC));
        vecs.push_back(mk(0, 0, 2'b11, 32'h10, 32'h11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b01, 0, 0, 32'hB,  32'hC));
        // 7 entries, write both: only lane 0 taken
        vecs.push_back(mk(0, 0, 2'b11, 32'h12, 32'h13, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 1, 0, 32'hB,  32'hC));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0, 32'hD,  32'hE));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0, 32'hF,  32'h10));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 0, 0, 32'h11, 32'h12));
        // last entry is 0x12: lane-1 data 0x13 never stored
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b01, 2'b00, 2'b01, 2'b01, 2'b11, 0, 0, 32'h12, 32'h0));
        vecs.push_back(mk(0, 1, 2'b00, 32'h0,  32'h0,  2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1, 32'h0,  32'h0));
        // single entry 0x55, pop both: only lane 0 taken
        vecs.push_back(mk(0, 0, 2'b01, 32'h55, 32'h0,  2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 0, 0, 32'h55, 32'h0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 0, 1, 32'h0,  32'h0));
        // pop on empty while writing: no bypass, pop dropped
        vecs.push_back(mk(0, 0, 2'b01, 32'h66, 32'h0,  2'b01, 2'b01, 2'b00, 2'b01, 2'b11, 0, 0, 32'h66, 32'h0));
        vecs.push_back(mk(0, 0, 2'b11, 32'h70, 32'h71, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h66, 32'h70));
        vecs.push_back(mk(0, 0, 2'b11, 32'h72, 32'h73, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h66, 32'h70));
        // 5 entries: flush with write and pop
        vecs.push_back(mk(0, 1, 2'b11, 32'h74, 32'h75, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 2'b11, 32'h80, 32'h81, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h80, 32'h81));
        vecs.push_back(mk(0, 0, 2'b11, 32'h82, 32'h83, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h80, 32'h81));
        // reset mid-stream with requests and flush asserted
        vecs.push_back(mk(1, 1, 2'b11, 32'h84, 32'h85, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 2'b11, 32'h90, 32'h91, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 32'h90, 32'h91));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].w_e, vecs[i].wd0, vecs[i].wd1, vecs[i].r_e);
            @(posedge clk);
            #1;
            check($sformatf("v%0d w_ack", i),   64'(w_ack),   64'(vecs[i].w_ack));
            check($sformatf("v%0d r_ack", i),   64'(r_ack),   64'(vecs[i].r_ack));
            check($sformatf("v%0d r_valid", i), 64'(r_valid), 64'(vecs[i].r_valid));
            check($sformatf("v%0d w_ready", i), 64'(w_ready), 64'(vecs[i].w_ready));
            check($sformatf("v%0d full", i),    64'(full),    64'(vecs[i].full));
            check($sformatf("v%0d empty", i),   64'(empty),   64'(vecs[i].empty));
            if (vecs[i].r_valid[0])
                check($sformatf("v%0d rd0", i), 64'(r_data[31:0]),  64'(vecs[i].rd0));
            if (vecs[i].r_valid[1])
                check($sformatf("v%0d rd1", i), 64'(r_data[63:32]), 64'(vecs[i].rd1));
`ifdef FIFO_NINO_WATERMARK_EN
            if (vecs[i].rst || vecs[i].flush) begin
                check($sformatf("v%0d count", i), 64'(count), 64'(0));
                check($sformatf("v%0d almost_full", i), 64'(almost_full), 64'(0));
            end
`endif
        end

        // Hand sequence: fill from 2 to 8 entries, then pop 2 + write 2 on
        // the full FIFO and check the start-of-cycle view before the edge.
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 2'b11, 32'hB0 + 32'(2*n), 32'hB1 + 32'(2*n), 2'b00);
        end
        drive(0, 0, 2'b11, 32'hC0, 32'hC1, 2'b11);
        #1;
        check("full_pre w_ready", 64'(w_ready), 64'(2'b00));
        check("full_pre r_valid", 64'(r_valid), 64'(2'b11));
        check("full_pre full",    64'(full),    64'(1));
        check("full_pre rd0",     64'(r_data[31:0]),  64'(32'h90));
        check("full_pre rd1",     64'(r_data[63:32]), 64'(32'h91));
`ifdef FIFO_NINO_WATERMARK_EN
        check("full_pre count",       64'(count),       64'(8));
        check("full_pre almost_full", 64'(almost_full), 64'(1));
`endif
        @(posedge clk);
        #1;
        check("full_post w_ack", 64'(w_ack), 64'(2'b00));
        check("full_post r_ack", 64'(r_ack), 64'(2'b11));
        check("full_post rd0",   64'(r_data[31:0]),  64'(32'hB0));
        check("full_post rd1",   64'(r_data[63:32]), 64'(32'hB1));
        check("full_post full",  64'(full), 64'(0));

        drive(0, 0, 2'b00, 32'h0, 32'h0, 2'b00);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
